// File: rtl/fp_align_shifter.sv
// Mantissa alignment stage for the FPU add/sub path: picks the larger operand by
// exponent, then shifts the smaller mantissa right one bit per cycle into {M, G, R, S}.
module fp_align_shifter #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 24,
    parameter int MAX_SHIFT = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [EXP_W-1:0]   exp_b,
    input  logic [MAN_W-1:0]   man_a,
    input  logic [MAN_W-1:0]   man_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   exp_out,
    output logic               sign_big,
    output logic               sign_small,
    output logic [MAN_W-1:0]   man_big,
    output logic [MAN_W+2:0]   man_small,
    output logic               swapped
);

    localparam int SM_W  = MAN_W + 3;
    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Differences beyond the mantissa plus G/R/S width all collapse into sticky.
    function automatic logic [CNT_W-1:0] sat_shift(input logic [EXP_W-1:0] mag);
        if (int'(mag) > MAX_SHIFT) begin
            return CNT_W'(MAX_SHIFT);
        end
        return CNT_W'(mag);
    endfunction

    function automatic logic [SM_W-1:0] sticky_shr(input logic [SM_W-1:0] m);
        return {1'b0, m[SM_W-1:2], m[1] | m[0]};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [EXP_W-1:0]   exp_out_q, exp_out_d;
    logic               sign_big_q, sign_big_d;
    logic               sign_small_q, sign_small_d;
    logic [MAN_W-1:0]   man_big_q, man_big_d;
    logic [SM_W-1:0]    man_small_q, man_small_d;
    logic               swapped_q, swapped_d;

    logic [EXP_W:0]     diff;
    logic               no_borrow;
    logic [EXP_W-1:0]   shift_mag;
    logic [CNT_W-1:0]   shift_cnt;

    always_comb begin
        diff      = {1'b0, exp_a} - {1'b0, exp_b};
        no_borrow = ~diff[EXP_W];
        shift_mag = no_borrow ? diff[EXP_W-1:0] : (exp_b - exp_a);
        shift_cnt = sat_shift(shift_mag);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_out_d    = exp_out_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        man_big_d    = man_big_q;
        man_small_d  = man_small_q;
        swapped_d    = swapped_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Equal exponents take the a-is-big path; mantissas are not compared.
                    if (no_borrow) begin
                        exp_out_d    = exp_a;
                        sign_big_d   = sign_a;
                        sign_small_d = sign_b;
                        man_big_d    = man_a;
                        man_small_d  = {man_b, 3'b000};
                        swapped_d    = 1'b0;
                    end else begin
                        exp_out_d    = exp_b;
                        sign_big_d   = sign_b;
                        sign_small_d = sign_a;
                        man_big_d    = man_b;
                        man_small_d  = {man_a, 3'b000};
                        swapped_d    = 1'b1;
                    end
                    cnt_d   = shift_cnt;
                    state_d = (shift_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                man_small_d = sticky_shr(man_small_q);
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            exp_out_q    <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            man_big_q    <= '0;
            man_small_q  <= '0;
            swapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            exp_out_q    <= exp_out_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            man_big_q    <= man_big_d;
            man_small_q  <= man_small_d;
            swapped_q    <= swapped_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign exp_out    = exp_out_q;
    assign sign_big   = sign_big_q;
    assign sign_small = sign_small_q;
    assign man_big    = man_big_q;
    assign man_small  = man_small_q;
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Bench for fp_align_shifter: directed scenarios plus random operand pairs checked
// against an arithmetic model of operand selection, saturated shift and sticky OR.
module tb_fp_align_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] man_a, man_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic        sign_big, sign_small;
    logic [23:0] man_big;
    logic [26:0] man_small;
    logic        swapped;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  e;
        logic        sb;
        logic        ss;
        logic [23:0] mb;
        logic [26:0] ms;
        logic        sw;
        logic [7:0]  lat;
    } res_t;

    fp_align_shifter #(.EXP_W(8), .MAN_W(24), .MAX_SHIFT(27)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_a(sign_a), .sign_b(sign_b),
        .exp_a(exp_a), .exp_b(exp_b),
        .man_a(man_a), .man_b(man_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .sign_big(sign_big), .sign_small(sign_small),
        .man_big(man_big), .man_small(man_small), .swapped(swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifting s places with a sticky LSB keeps value>>s and ORs every bit at or below s into bit 0.
    function automatic res_t model(input logic [7:0] ea, input logic [7:0] eb,
                                   input logic [23:0] ma, input logic [23:0] mb,
                                   input logic sa, input logic sb);
        res_t r;
        int s;
        longint unsigned v, mask;
        if (int'(ea) >= int'(eb)) begin
            r.e = ea; r.sb = sa; r.ss = sb; r.mb = ma; r.sw = 1'b0;
            s = int'(ea) - int'(eb);
            v = longint'(mb);
        end else begin
            r.e = eb; r.sb = sb; r.ss = sa; r.mb = mb; r.sw = 1'b1;
            s = int'(eb) - int'(ea);
            v = longint'(ma);
        end
        if (s > 27) s = 27;
        v = v * 8;
        mask = (64'd1 << (s + 1)) - 64'd1;
        r.ms = 27'((v >> s) | (((v & mask) != 64'd0) ? 64'd1 : 64'd0));
        r.lat = 8'(1 + s);
        return r;
    endfunction

    function automatic res_t snap(input logic [7:0] lat);
        res_t r;
        r = {exp_out, sign_big, sign_small, man_big, man_small, swapped, lat};
        return r;
    endfunction

    // Presents one operand pair, scrambles inputs after the accept edge, and
    // returns the outputs plus the cycle count (accept cycle = 1) to out_valid.
    task automatic drive_op(input logic [7:0] ea, input logic [7:0] eb,
                            input logic [23:0] ma, input logic [23:0] mb,
                            input logic sa, input logic sb, output res_t obs);
        int lat;
        @(negedge clk);
        exp_a = ea; exp_b = eb; man_a = ma; man_b = mb; sign_a = sa; sign_b = sb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_a = 8'($urandom); exp_b = 8'($urandom);
        man_a = 24'($urandom); man_b = 24'($urandom);
        sign_a = 1'($urandom); sign_b = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        obs = snap(8'(lat));
    endtask

    task automatic release_op(output logic ov, output logic ir);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        ov = out_valid;
        ir = in_ready;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_t z;
        z = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sign_a = 0; sign_b = 0; exp_a = 0; exp_b = 0; man_a = 0; man_b = 0;
        #2;
        checks++;
        if (snap(8'd0) !== z || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got %h ov=%b want 0", snap(8'd0), out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb,
                                 input logic [26:0] ms_lit, input int lat_lit);
        res_t obs, exp_r;
        logic ov, ir;
        exp_r = model(ea, eb, ma, mb, 1'b0, 1'b1);
        drive_op(ea, eb, ma, mb, 1'b0, 1'b1, obs);
        checks++;
        if (obs !== exp_r) begin
            failures++;
            $display("FAIL %s got %h want %h", name, obs, exp_r);
        end
        checks++;
        if (obs.ms !== ms_lit || int'(obs.lat) != lat_lit) begin
            failures++;
            $display("FAIL %s_literal got ms=%h lat=%0d want ms=%h lat=%0d",
                     name, obs.ms, obs.lat, ms_lit, lat_lit);
        end
        release_op(ov, ir);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            failures++;
            $display("FAIL %s_handshake got ov=%b ir=%b want ov=0 ir=1", name, ov, ir);
        end
    endtask

    task automatic test_backpressure();
        res_t obs, exp_r, held, cur;
        logic ov, ir;
        exp_r = model(8'h85, 8'h83, 24'hABCDEF, 24'h812345, 1'b1, 1'b0);
        drive_op(8'h85, 8'h83, 24'hABCDEF, 24'h812345, 1'b1, 1'b0, obs);
        checks++;
        if (obs !== exp_r) begin
            failures++;
            $display("FAIL bp_result got %h want %h", obs, exp_r);
        end
        held = snap(8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            exp_a = 8'($urandom); exp_b = 8'($urandom);
            man_a = 24'($urandom); man_b = 24'($urandom);
            @(posedge clk);
            #1;
            cur = snap(8'd0);
            checks++;
            if (cur !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got %h ov=%b ir=%b want %h ov=1 ir=0",
                         i, cur, out_valid, in_ready, held);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_op(ov, ir);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", ov, ir);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_accept got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        res_t obs, exp_r, z;
        logic ov, ir;
        z = '0;
        @(negedge clk);
        exp_a = 8'h94; exp_b = 8'h80; man_a = 24'hC00001; man_b = 24'hFFFFFF;
        sign_a = 1'b1; sign_b = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (snap(8'd0) !== z || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got %h ov=%b ir=%b want 0 ov=0 ir=1",
                     snap(8'd0), out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_r = model(8'h70, 8'h74, 24'h876543, 24'hF00000, 1'b0, 1'b1);
        drive_op(8'h70, 8'h74, 24'h876543, 24'hF00000, 1'b0, 1'b1, obs);
        checks++;
        if (obs !== exp_r) begin
            failures++;
            $display("FAIL reset_mid_recover got %h want %h", obs, exp_r);
        end
        release_op(ov, ir);
    endtask

    task automatic test_random();
        res_t obs, exp_r;
        logic ov, ir;
        logic [7:0] ea, eb;
        logic [23:0] ma, mb;
        logic sa, sb;
        int d;
        for (int i = 0; i < 40; i++) begin
            ea = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                eb = 8'($urandom);
            end else begin
                d = int'($urandom_range(0, 30));
                eb = ($urandom_range(0, 1) == 1) ? 8'(int'(ea) + d) : 8'(int'(ea) - d);
            end
            ma = ($urandom_range(0, 7) == 0) ? 24'h0 : (24'($urandom) | 24'h800000);
            mb = ($urandom_range(0, 7) == 0) ? 24'($urandom_range(0, 15)) : (24'($urandom) | 24'h800000);
            sa = 1'($urandom); sb = 1'($urandom);
            exp_r = model(ea, eb, ma, mb, sa, sb);
            drive_op(ea, eb, ma, mb, sa, sb, obs);
            checks++;
            if (obs !== exp_r) begin
                failures++;
                $display("FAIL random_%0d ea=%h eb=%h ma=%h mb=%h got %h want %h",
                         i, ea, eb, ma, mb, obs, exp_r);
            end
            release_op(ov, ir);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                failures++;
                $display("FAIL random_%0d_handshake got ov=%b ir=%b want ov=0 ir=1", i, ov, ir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed("basic", 8'h82, 8'h80, 24'hC00000, 24'h800000, 27'h1000000, 3);
        test_directed("swap", 8'h7F, 8'h81, 24'hFFFFFF, 24'h900000, 27'h1FFFFFE, 3);
        test_directed("saturate_nz", 8'hFE, 8'h01, 24'h123456, 24'h800001, 27'h1, 28);
        test_directed("saturate_zero", 8'hFE, 8'h01, 24'h123456, 24'h000000, 27'h0, 28);
        test_directed("equal_exp", 8'h90, 8'h90, 24'h800000, 24'hA00000, 27'h5000000, 1);
        test_directed("shift_27", 8'h20, 8'h3B, 24'h000001, 24'h800000, 27'h1, 28);
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_align_shifter.md
Name: fp_align_shifter

Overview:
- Mantissa-alignment stage of the FPU add/sub path. It sits directly downstream of the 8-bit exponent subtractor.
- It accepts two unpacked operands and decides from the exponent difference and borrow which operand is larger. It then right-shifts the smaller mantissa one bit per cycle, producing guard, round and sticky bits.
- Aligned operands go to the mantissa adder under a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 24, mantissa width including hidden bit.
- MAX_SHIFT, 27, shift cap (MAN_W+3); larger differences saturate to this value.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- sign_a, sign_b  in  1 each  operand signs.
- exp_a, exp_b  in  EXP_W each  biased exponents.
- man_a, man_b  in  MAN_W each  mantissas, hidden bit included.
- out_valid  out  1  aligned result present.
- out_ready  in  1  downstream accepts result.
- exp_out  out  EXP_W  larger exponent.
- sign_big, sign_small  out  1 each  signs of the larger and smaller operand.
- man_big  out  MAN_W  unshifted larger mantissa.
- man_small  out  MAN_W+3  shifted smaller mantissa, laid out as {mantissa, G, R, S}.
- swapped  out  1  1 when operand b is the larger.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All registered outputs and the counter clear to 0: out_valid, exp_out, man_big, man_small, signs, swapped.
  - in_ready=1 while in IDLE, including during reset.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE), combinational. out_valid = (state==DONE), registered.
- IDLE, on in_valid (accept cycle):
  - Compute d = exp_a - exp_b at EXP_W+1 bits. no_borrow = (exp_a >= exp_b).
  - Borrow-free (exponents equal included): big=a, small=b, swapped=0, shift = d.
  - Otherwise: big=b, small=a, swapped=1, shift = exp_b - exp_a.
  - No mantissa comparison is made on equal exponents.
  - Register exp_out, man_big, sign_big and sign_small.
  - Load man_small = {man_small_src, 3'b000}. Load cnt = min(shift, MAX_SHIFT).
  - Next state is SHIFT if cnt!=0, else DONE.
- SHIFT, each cycle:
  - man_small <= {1'b0, man_small[MAN_W+2:1]}, with new bit0 = man_small[1] | man_small[0].
  - Bit0 is therefore sticky: once set it stays set.
  - cnt <= cnt-1. When cnt==1, next state is DONE.
- Latency: out_valid rises exactly 1+cnt cycles after the accept edge (cnt=0 gives 1 cycle, cnt=27 gives 28 cycles).
- Saturation: shift ≥ MAX_SHIFT collapses all mantissa bits into S. man_small = 1 if the source mantissa is nonzero, else 0.
- DONE:
  - All outputs are held stable while out_ready=0.
  - On out_ready=1, return to IDLE next cycle; out_valid drops.
  - There is no accept in the same cycle as completion; throughput is one operation per 2+cnt cycles.
- in_valid outside IDLE is ignored; upstream must hold its operands until in_ready.
- Input fields are sampled only on the accept edge. Later input changes do not affect the operation in flight.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. No output is produced for it.
- Denormals, zero and NaN get no special handling: fields are processed arithmetically as given.

Test Plan:
- Basic alignment: exp_a=0x82, exp_b=0x80, man_a=0xC00000, man_b=0x800000 -> out_valid 3 cycles after accept; exp_out=0x82, swapped=0, man_big=0xC00000, man_small=27'h1000000.
- Swap path: exp_a=0x7F, exp_b=0x81, man_a=0xFFFFFF, man_b=0x900000 -> swapped=1, exp_out=0x81, man_big=0x900000, man_small=27'h1FFFFFE (mantissa 0x3FFFFF, G=1, R=1, S=0).
- Saturation: exp_a=0xFE, exp_b=0x01, man_b=0x800001 -> cnt capped at 27, out_valid 28 cycles after accept, man_small=27'h1; repeat with man_b=0 -> man_small=0.
- Equal exponents: exp_a=exp_b=0x90, man_a=0x800000, man_b=0xA00000 -> out_valid 1 cycle after accept, swapped=0, man_small=27'h5000000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> outputs unchanged, in_ready=0, new operands not accepted; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: drop rst_n during SHIFT of a diff=20 operation -> out_valid=0, in_ready=1 and all outputs 0 immediately; after release the next operation completes normally.
